// File: rtl/kdispatch_pkg.sv
// Shared types and default sizes for the kernel dispatch arbiter.
package kdispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } kd_state_e;

  localparam int KD_NREQ_DEF        = 4;
  localparam int KD_N_W_DEF         = 6;
  localparam int KD_D_W_DEF         = 32;
  localparam int KD_TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/kernel_dispatch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first requester after ptr
// (circularly) that is asserting req, as a one-hot grant and an index.
// Reusable by any scheduler sharing a single resource.
module rr_arbiter
  import kdispatch_pkg::*;
#(
  parameter int NREQ  = KD_NREQ_DEF,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic found_s;
  int   cand_s;

  // Circular search starting one past the last winner.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = (int'(ptr) + k) % NREQ;
      if (en && !found_s && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        idx           = IDX_W'(cand_s);
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/kernel_dispatch_arbiter.sv
// Shares one start/done kernel among NREQ requesters. One job in flight:
// IDLE (round-robin grant) -> START (one-cycle pulse) -> WAIT (kernel done)
// -> RESP (id-tagged response until accepted) -> IDLE.
// Optional macro KDISPATCH_TIMEOUT_EN: abort a job after TIMEOUT_CYC WAIT
// cycles with rsp_err=1 and rsp_data=0.
module kernel_dispatch_arbiter
  import kdispatch_pkg::*;
#(
  parameter int NREQ        = KD_NREQ_DEF,
  parameter int N_W         = KD_N_W_DEF,
  parameter int D_W         = KD_D_W_DEF,
  parameter int TIMEOUT_CYC = KD_TIMEOUT_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N_W-1:0]       req_n,
  input  logic [NREQ*D_W-1:0]       req_a,
  input  logic [NREQ*D_W-1:0]       req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [D_W-1:0]            rsp_data,
  output logic                      rsp_err,
  output logic                      k_start,
  output logic [N_W-1:0]            k_n,
  output logic [D_W-1:0]            k_a,
  output logic [D_W-1:0]            k_b,
  input  logic                      k_done,
  input  logic [D_W-1:0]            k_result,
  output logic                      busy,
  output logic [15:0]               jobs_done
);

  localparam int IDX_W = $clog2(NREQ);

  kd_state_e        state_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [NREQ-1:0]  grant_s;
  logic [IDX_W-1:0] grant_idx_s;
  logic             arb_en_s;
  logic             to_hit_s;

  // Grants are only offered while idle; req_ready is the raw one-hot grant.
  assign arb_en_s  = (state_r == IDLE);
  assign req_ready = grant_s;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .en    (arb_en_s),
    .grant (grant_s),
    .idx   (grant_idx_s)
  );

`ifdef KDISPATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_r;

  assign to_hit_s = (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  // WAIT-cycle counter: cleared in START (entry to WAIT), counts in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (state_r == START) begin
      to_cnt_r <= '0;
    end else if (state_r == WAIT) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end
`else
  logic unused_timeout_s;

  assign to_hit_s         = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYC != 32'sd0);
`endif

  // Dispatch FSM with registered kernel args, response and bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rr_ptr_r  <= IDX_W'(NREQ - 1);
      k_start   <= 1'b0;
      k_n       <= '0;
      k_a       <= '0;
      k_b       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      jobs_done <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            k_n      <= req_n[grant_idx_s*N_W +: N_W];
            k_a      <= req_a[grant_idx_s*D_W +: D_W];
            k_b      <= req_b[grant_idx_s*D_W +: D_W];
            rsp_id   <= grant_idx_s;
            rr_ptr_r <= grant_idx_s;
            k_start  <= 1'b1;
            busy     <= 1'b1;
            state_r  <= START;
          end else begin
            k_start <= 1'b0;
            state_r <= IDLE;
          end
        end
        START: begin
          // k_done still reflects the previous job here; do not look at it.
          k_start <= 1'b0;
          state_r <= WAIT;
        end
        WAIT: begin
          if (k_done) begin
            rsp_data  <= k_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else if (to_hit_s) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          k_start   <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/kernel_dispatch_arbiter.md
Name: kernel_dispatch_arbiter

Overview:
Shares one synthesized kernel instance (start/done handshake, 6-bit count arg, two 32-bit data args, 32-bit result) among NREQ requesters. Round-robin arbitration picks a pending request, loads the args and pulses the kernel start, waits for done, and returns an id-tagged result on a shared response channel. Sits between client FSMs and the generated kernel top; one job is in flight at a time.

Parameters:
NREQ, 4, number of requesters (2..8)
N_W, 6, width of kernel count argument
D_W, 32, width of kernel data args and result
TIMEOUT_CYC, 1024, WAIT-state cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_n  in  NREQ*N_W  packed count args, slice i for requester i
req_a  in  NREQ*D_W  packed first data args
req_b  in  NREQ*D_W  packed second data args
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  $clog2(NREQ)  requester index of the response
rsp_data  out  D_W  kernel result
rsp_err  out  1  job aborted by timeout (constant 0 without the feature)
k_start  out  1  to kernel r_enable, one-cycle pulse
k_n  out  N_W  to kernel count input, registered
k_a  out  D_W  to kernel data input a, registered
k_b  out  D_W  to kernel data input b, registered
k_done  in  1  from kernel w_enable; level, sticky until next start
k_result  in  D_W  from kernel result; valid while k_done=1
busy  out  1  high in any state other than IDLE
jobs_done  out  16  count of completed responses, wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync deassert by the caller) puts state=IDLE, rr_ptr=NREQ-1, all outputs 0, k_* arg regs 0, jobs_done 0. The kernel has no reset. Its k_done is ignored until the first START.
- States: IDLE -> START -> WAIT -> RESP -> IDLE.
- IDLE: grant = first i with req_valid[i], searching from rr_ptr+1 circularly. req_ready is the one-hot grant, combinational from req_valid while in IDLE, and 0 in all other states. On valid&ready: capture slices into k_n/k_a/k_b, latch id, set rr_ptr=id, go START. With no request, stay in IDLE.
- START: k_start=1 for exactly one cycle. k_done is stale in this cycle and must be ignored. Go WAIT.
- WAIT: when k_done=1, latch rsp_data=k_result and rsp_err=0, then go RESP. The earliest sample is the cycle after START.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready. On handshake: jobs_done+1 (wrapping), go IDLE. A new grant is allowed no earlier than the following cycle.
- Fairness: a requester that stays valid is served within NREQ jobs. A requester whose valid drops before grant is simply skipped. The ptr changes only on grant.
- req_valid asserted during START/WAIT/RESP stays pending and is not accepted.
- Reset mid-job: the job is lost and no response is produced. The kernel may keep running, but the next START reloads it, because r_enable overrides the kernel state.
- Latency: 1 (grant) + 1 (START) + kernel run + 1 (WAIT sample) cycles to rsp_valid.

Optional Feature:
Macro KDISPATCH_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYC without k_done, go RESP with rsp_data=0 and rsp_err=1. The kernel is left as is and is re-armed by the next START.
- Undefined: no counter, rsp_err tied 0, and WAIT persists until k_done.

Decomposition:
- Package kdispatch_pkg: state enum (IDLE, START, WAIT, RESP), default widths, TIMEOUT_CYC default.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector, ptr, enable; outputs one-hot grant and encoded index. Pure combinational, reusable by other shared-resource schedulers.

Test Plan:
- Requester 0 alone: n=10, a=1, b=0 with the fib kernel attached -> one response, rsp_id=0, rsp_data=89, rsp_err=0, jobs_done=1.
- n=0, a=7, b=3 -> rsp_data=7. Checks: k_start high exactly one cycle; k_done ignored in the START cycle.
- All 4 requesters held valid (n=i+1, a=1, b=0) -> grants in order 0,1,2,3,0, results 1,2,3,5 per id. No requester is starved.
- rsp_ready held 0 for 20 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable; req_ready stays 0; on release, jobs_done increments once.
- rst_n asserted mid-WAIT, then a new job n=3, a=1, b=0 -> no stale response; new job returns 3.
- With KDISPATCH_TIMEOUT_EN, TIMEOUT_CYC=16, kernel k_done stuck 0 -> after 16 WAIT cycles, rsp_err=1 and rsp_data=0; the next job completes normally.
